dsc_chunk_unpacker: RTL and testbench
=====================================

// Module: dsc_chunk_unpacker
// PURPOSE
//  Decoder-side front end of the DSC datapath. It consumes the compressed slice bytestream that the
//  encoder writes into cmpr_buf, one byte per beat, and splits it into per-row chunks of cfg_chunk_size
//  bytes. It packs each chunk MSB-first into BPW-byte words for the substream demux.
//  Tags every word with chunk and slice boundaries, and pulses done when a full slice is unpacked.
// PARAMETERS
//  BPW      6   bytes per output word (6 = 48-bit mux word)
//  CNT_W    16  width of chunk-size and slice-height counters
// PORTS
//  clk             in   1        single clock
//  rst_n           in   1        asynchronous active-low reset
//  start           in   1        pulse; latch cfg_*, begin one slice
//  cfg_chunk_size  in   CNT_W    bytes per chunk (per slice row), >=1
//  cfg_slice_height in  CNT_W    chunks per slice, >=1
//  in_valid        in   1        byte available
//  in_ready        out  1        byte accepted when in_valid&in_ready
//  in_data         in   8        compressed byte
//  out_valid       out  1        word available
//  out_ready       in   1        word consumed when out_valid&out_ready
//  out_data        out  8*BPW    first byte in [8*BPW-1 -: 8]
//  out_ben         out  BPW      byte enables, MSB-aligned contiguous (e.g. 6'b111000)
//  out_last_chunk  out  1        word holds last byte of a chunk
//  out_last_slice  out  1        word holds last byte of the slice
//  busy            out  1        high from accepted start until done
//  done            out  1        1-cycle pulse after last word handshakes
//  err_cfg         out  1        sticky: start seen with zero size/height
// BEHAVIOUR
//  - Reset (async, any state): all outputs 0, FSM IDLE, counters/accumulator/output reg cleared.
//    A slice in flight is discarded. No done is issued for it.
//  - FSM: IDLE --start & cfg ok--> RUN --last slice byte accepted--> DRAIN --last word handshake--> IDLE.
//    Entering IDLE from DRAIN pulses done.
//  - start with cfg_chunk_size==0 or cfg_slice_height==0: err_cfg<=1, stay IDLE.
//    err_cfg clears on the next valid start. start is ignored while busy.
//  - cfg_* are sampled only on the accepted start. Later changes have no effect until the next slice.
//  - in_ready = (state==RUN) & (~out_valid | out_ready). One byte per cycle sustained while the sink is ready.
//  - Accepted byte goes to accumulator lane byte_cnt%BPW. Accumulator moves to the output register in the
//    same cycle when the lane is BPW-1 or the byte is the last of its chunk. out_valid rises next cycle (1-cycle latency).
//  - Chunk-final word may be partial; out_ben marks the valid lanes. Invalid lanes are driven 0.
//    Chunks never share a word; each chunk starts in lane 0.
//  - byte_cnt wraps to 0 at cfg_chunk_size-1 and row_cnt increments.
//    At row_cnt==cfg_slice_height-1 that word also sets out_last_slice.
//  - out_valid/out_data/flags stay stable while out_valid & ~out_ready.
//  - A simultaneous out handshake and new word load in one cycle is legal; out_valid stays 1.
//  - Counters are CNT_W bits. The maximum cfg values (2^CNT_W-1) must work without overflow.
// CONFIGURATION
//  DSC_UNPACK_CRC_EN defined: adds ports crc_out (out, 16) and crc_valid (out, 1).
//   CRC-16-CCITT (poly 0x1021, init 0xFFFF, MSB-first, no final xor) runs over every accepted byte of the slice.
//   crc_valid pulses with done and crc_out holds until the next accepted start. Both are 0 after reset.
//  DSC_UNPACK_CRC_EN undefined: no CRC logic, and the two ports do not exist. All other behaviour is identical.
// TESTING
//  1) chunk=6, height=1, bytes 01..06, out_ready=1 -> one word 0x010203040506, ben 111111,
//     last_chunk=last_slice=1, done 1 cycle later.
//  2) chunk=8, height=2, bytes 00..0F -> 4 words: 000102030405/111111; 0607xxxx->060700000000/110000 last_chunk;
//     08..0D/111111; 0E0F00000000/110000 last_chunk+last_slice.
//  3) Test 2 with out_ready held low 5 cycles mid-slice -> in_ready low, out_data stable, no byte lost, same word sequence.
//  4) start with chunk=0 -> err_cfg=1, busy=0, in_ready=0. Then start with chunk=3, height=1 -> err_cfg=0, slice completes.
//  5) rst_n low for 1 cycle after 4 of 12 bytes -> all outputs 0 immediately, no done.
//     A fresh slice afterwards completes correctly.
//  6) [DSC_UNPACK_CRC_EN] chunk=9, height=1, ASCII "123456789" -> crc_out=0x29B1 with crc_valid=done.

Source files
------------

// File: rtl/dsc_chunk_unpacker.sv
// DSC decoder front end: splits the compressed slice bytestream into per-row chunks and packs them
// MSB-first into BPW-byte words tagged with chunk/slice boundaries. Define DSC_UNPACK_CRC_EN for slice CRC-16.
module dsc_chunk_unpacker #(
    parameter int BPW   = 6,
    parameter int CNT_W = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [CNT_W-1:0]     cfg_chunk_size_i,
    input  logic [CNT_W-1:0]     cfg_slice_height_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [7:0]           in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [8*BPW-1:0]     out_data_o,
    output logic [BPW-1:0]       out_ben_o,
    output logic                 out_last_chunk_o,
    output logic                 out_last_slice_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_cfg_o
`ifdef DSC_UNPACK_CRC_EN
    ,
    output logic [15:0]          crc_out_o,
    output logic                 crc_valid_o
`endif
);

    localparam int LW = (BPW > 1) ? $clog2(BPW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [LW-1:0]    LANE_MAX  = LW'(BPW - 1);
    localparam logic [LW:0]      LANE_ONE  = 1;

    logic [1:0]           state_q, state_d;
    logic [CNT_W-1:0]     chunkSize_q, chunkSize_d;
    logic [CNT_W-1:0]     height_q, height_d;
    logic [CNT_W-1:0]     byteCnt_q, byteCnt_d;
    logic [CNT_W-1:0]     rowCnt_q, rowCnt_d;
    logic [LW-1:0]        lane_q, lane_d;
    logic [8*BPW-1:0]     acc_q, acc_d;
    logic                 outValid_q, outValid_d;
    logic [8*BPW-1:0]     outData_q, outData_d;
    logic [BPW-1:0]       outBen_q, outBen_d;
    logic                 outLastChunk_q, outLastChunk_d;
    logic                 outLastSlice_q, outLastSlice_d;
    logic                 done_q, done_d;
    logic                 errCfg_q, errCfg_d;

    logic                 cfgOk, startOk, inReady, inFire, outFire;
    logic                 chunkEnd, sliceEnd, laneFull, flush;
    logic [LW+2:0]        shamt;
    logic [LW:0]          lanePlusOne;
    logic [8*BPW-1:0]     insWord;
    logic [BPW-1:0]       benNew;

    assign cfgOk    = (|cfg_chunk_size_i) & (|cfg_slice_height_i);
    assign startOk  = (state_q == S_IDLE) & start_i & cfgOk;
    assign inReady  = (state_q == S_RUN) & (~outValid_q | out_ready_i);
    assign inFire   = in_valid_i & inReady;
    assign outFire  = outValid_q & out_ready_i;
    assign chunkEnd = (byteCnt_q == chunkSize_q - CNT_ONE);
    assign sliceEnd = chunkEnd & (rowCnt_q == height_q - CNT_ONE);
    assign laneFull = (lane_q == LANE_MAX);
    assign flush    = inFire & (laneFull | chunkEnd);

    // Incoming byte positioned at its lane; byte enables cover lanes 0..lane, MSB-aligned.
    assign shamt       = {lane_q, 3'b000};
    assign lanePlusOne = {1'b0, lane_q} + LANE_ONE;
    assign benNew      = ~({BPW{1'b1}} >> lanePlusOne);

    always_comb begin
        insWord = '0;
        insWord[8*BPW-1 -: 8] = in_data_i;
        insWord = insWord >> shamt;
    end

    always_comb begin
        state_d        = state_q;
        chunkSize_d    = chunkSize_q;
        height_d       = height_q;
        byteCnt_d      = byteCnt_q;
        rowCnt_d       = rowCnt_q;
        lane_d         = lane_q;
        acc_d          = acc_q;
        outValid_d     = outValid_q;
        outData_d      = outData_q;
        outBen_d       = outBen_q;
        outLastChunk_d = outLastChunk_q;
        outLastSlice_d = outLastSlice_q;
        done_d         = 1'b0;
        errCfg_d       = errCfg_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    if (cfgOk) begin
                        chunkSize_d = cfg_chunk_size_i;
                        height_d    = cfg_slice_height_i;
                        byteCnt_d   = '0;
                        rowCnt_d    = '0;
                        lane_d      = '0;
                        acc_d       = '0;
                        errCfg_d    = 1'b0;
                        state_d     = S_RUN;
                    end else begin
                        errCfg_d    = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (inFire) begin
                    if (chunkEnd) begin
                        byteCnt_d = '0;
                        lane_d    = '0;
                        rowCnt_d  = rowCnt_q + CNT_ONE;
                    end else begin
                        byteCnt_d = byteCnt_q + CNT_ONE;
                        lane_d    = laneFull ? '0 : lane_q + 1'b1;
                    end
                    acc_d = flush ? '0 : (acc_q | insWord);
                    if (sliceEnd) begin
                        state_d = S_DRAIN;
                    end
                end
            end
            S_DRAIN: begin
                if (outFire && outLastSlice_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A flush only happens when the output register is empty or being drained this cycle.
        if (flush) begin
            outValid_d     = 1'b1;
            outData_d      = acc_q | insWord;
            outBen_d       = benNew;
            outLastChunk_d = chunkEnd;
            outLastSlice_d = sliceEnd;
        end else if (outFire) begin
            outValid_d     = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= S_IDLE;
            chunkSize_q    <= '0;
            height_q       <= '0;
            byteCnt_q      <= '0;
            rowCnt_q       <= '0;
            lane_q         <= '0;
            acc_q          <= '0;
            outValid_q     <= 1'b0;
            outData_q      <= '0;
            outBen_q       <= '0;
            outLastChunk_q <= 1'b0;
            outLastSlice_q <= 1'b0;
            done_q         <= 1'b0;
            errCfg_q       <= 1'b0;
        end else begin
            state_q        <= state_d;
            chunkSize_q    <= chunkSize_d;
            height_q       <= height_d;
            byteCnt_q      <= byteCnt_d;
            rowCnt_q       <= rowCnt_d;
            lane_q         <= lane_d;
            acc_q          <= acc_d;
            outValid_q     <= outValid_d;
            outData_q      <= outData_d;
            outBen_q       <= outBen_d;
            outLastChunk_q <= outLastChunk_d;
            outLastSlice_q <= outLastSlice_d;
            done_q         <= done_d;
            errCfg_q       <= errCfg_d;
        end
    end

    assign in_ready_o       = inReady;
    assign out_valid_o      = outValid_q;
    assign out_data_o       = outData_q;
    assign out_ben_o        = outBen_q;
    assign out_last_chunk_o = outLastChunk_q;
    assign out_last_slice_o = outLastSlice_q;
    assign busy_o           = (state_q != S_IDLE);
    assign done_o           = done_q;
    assign err_cfg_o        = errCfg_q;

`ifdef DSC_UNPACK_CRC_EN
    // CRC-16-CCITT, MSB-first, one byte per accepted beat.
    function automatic logic [15:0] crcByte(input logic [15:0] crcIn, input logic [7:0] dataIn);
        logic [15:0] c;
        c = crcIn;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ dataIn[i]) begin
                c = {c[14:0], 1'b0} ^ 16'h1021;
            end else begin
                c = {c[14:0], 1'b0};
            end
        end
        return c;
    endfunction

    logic [15:0] crc_q;
    logic        crcValid_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            crc_q      <= '0;
            crcValid_q <= 1'b0;
        end else begin
            crcValid_q <= done_d;
            if (startOk) begin
                crc_q <= 16'hFFFF;
            end else if (inFire) begin
                crc_q <= crcByte(crc_q, in_data_i);
            end
        end
    end

    assign crc_out_o   = crc_q;
    assign crc_valid_o = crcValid_q;
`endif

endmodule

// File: tb/tb_dsc_chunk_unpacker.sv
// Randomized bench for dsc_chunk_unpacker: a chunk/row model builds the expected word list from the byte
// stream; handshakes are checked at negedge. Define DSC_UNPACK_CRC_EN to also check the slice CRC.
module tb_dsc_chunk_unpacker;

    localparam int BPW = 6;

    typedef struct {
        logic [47:0] data;
        logic [5:0]  ben;
        logic        lastChunk;
        logic        lastSlice;
    } word_t;

    logic        clk = 1'b0;
    logic        rstN;
    logic        start;
    logic [15:0] cfgChunkSize, cfgSliceHeight;
    logic        inValid, inReady;
    logic [7:0]  inData;
    logic        outValid, outReady;
    logic [47:0] outData;
    logic [5:0]  outBen;
    logic        outLastChunk, outLastSlice, busy, done, errCfg;
`ifdef DSC_UNPACK_CRC_EN
    logic [15:0] crcOut;
    logic        crcValid;
`endif

    int          assertCount = 0;
    int          failCount   = 0;
    byte unsigned stim[$];
    word_t       expQ[$];
    logic [47:0] firstWordData;
    logic [15:0] lastCrc;

    always #5 clk = ~clk;

    dsc_chunk_unpacker #(.BPW(BPW), .CNT_W(16)) dut (
        .clk_i              (clk),
        .rst_ni             (rstN),
        .start_i            (start),
        .cfg_chunk_size_i   (cfgChunkSize),
        .cfg_slice_height_i (cfgSliceHeight),
        .in_valid_i         (inValid),
        .in_ready_o         (inReady),
        .in_data_i          (inData),
        .out_valid_o        (outValid),
        .out_ready_i        (outReady),
        .out_data_o         (outData),
        .out_ben_o          (outBen),
        .out_last_chunk_o   (outLastChunk),
        .out_last_slice_o   (outLastSlice),
        .busy_o             (busy),
        .done_o             (done),
        .err_cfg_o          (errCfg)
`ifdef DSC_UNPACK_CRC_EN
        ,
        .crc_out_o          (crcOut),
        .crc_valid_o        (crcValid)
`endif
    );

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Each row of c bytes is cut into BPW-byte groups; the last group of a row may be short.
    function automatic void buildModel(input int c, input int h);
        expQ.delete();
        for (int r = 0; r < h; r++) begin
            for (int off = 0; off < c; off += BPW) begin
                word_t w;
                int    n;
                n = (c - off < BPW) ? (c - off) : BPW;
                w.data = '0;
                for (int k = 0; k < n; k++) begin
                    w.data = w.data | (48'(stim[r*c + off + k]) << (8*(BPW-1-k)));
                end
                w.ben       = 6'((((1 << n) - 1) << (BPW - n)));
                w.lastChunk = (off + n == c);
                w.lastSlice = w.lastChunk && (r == h - 1);
                expQ.push_back(w);
            end
        end
    endfunction

    function automatic logic [15:0] crcModel();
        logic [15:0] c;
        c = 16'hFFFF;
        foreach (stim[i]) begin
            c = c ^ {stim[i], 8'h00};
            for (int b = 0; b < 8; b++) begin
                c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
            end
        end
        return c;
    endfunction

    function automatic void fillRandom(input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
    endfunction

    function automatic void fillCount(input int first, input int n);
        stim.delete();
        for (int i = 0; i < n; i++) stim.push_back(8'(first + i));
    endfunction

    // Runs one slice with random pacing; abortAt>0 returns right after that many bytes are accepted.
    task automatic applyStimulus(input int c, input int h, input int validPct, input int readyPct,
                                 input int holdAt, input int holdLen, input int abortAt);
        int          n, idx, budget, lastHs;
        bit          running, doneSeen, prevStall, gotFirst;
        logic [47:0] heldData;
        logic [5:0]  heldBen;
        word_t       w;
        n = c * h;
        buildModel(c, h);
        idx = 0; running = 1; doneSeen = 0; prevStall = 0; gotFirst = 0; lastHs = -10;
        heldData = '0; heldBen = '0;
        budget = 20 * n + 200;
        @(posedge clk); #1;
        start = 1'b1; cfgChunkSize = 16'(c); cfgSliceHeight = 16'(h);
        inValid = 1'b0; outReady = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("busy_after_start", busy, 1'b1);
        checkOutput("err_after_start", errCfg, 1'b0);
        @(posedge clk); #1;
        for (int cyc = 0; cyc < budget && !doneSeen; cyc++) begin
            inValid  = running && (idx < n) && ($urandom_range(99) < validPct);
            inData   = (idx < n) ? stim[idx] : 8'($urandom);
            outReady = (holdAt >= 0 && cyc >= holdAt && cyc < holdAt + holdLen) ? 1'b0
                       : ($urandom_range(99) < readyPct);
            start    = running && (idx < n) && ($urandom_range(7) == 0);
            cfgChunkSize   = 16'($urandom);
            cfgSliceHeight = 16'($urandom);
            @(negedge clk);
            checkOutput("in_ready", inReady, running && (!outValid || outReady));
            if (prevStall) begin
                checkOutput("stall_valid", outValid, 1'b1);
                checkOutput("stall_data", outData, heldData);
                checkOutput("stall_ben", outBen, heldBen);
            end
            if (outValid && outReady) begin
                if (expQ.size() == 0) begin
                    checkOutput("extra_word", 1, 0);
                end else begin
                    w = expQ.pop_front();
                    checkOutput("word_data", outData, w.data);
                    checkOutput("word_ben", outBen, w.ben);
                    checkOutput("word_last_chunk", outLastChunk, w.lastChunk);
                    checkOutput("word_last_slice", outLastSlice, w.lastSlice);
                    if (!gotFirst) firstWordData = outData;
                    gotFirst = 1;
                end
                lastHs = cyc;
            end
            prevStall = outValid && !outReady;
            heldData  = outData;
            heldBen   = outBen;
            if (inValid && inReady) begin
                idx++;
                if (idx == n) running = 0;
                if (idx == abortAt) return;
            end
            if (done) begin
                doneSeen = 1;
                checkOutput("done_timing", 64'(cyc), 64'(lastHs + 1));
                checkOutput("words_left", 64'(expQ.size()), 0);
                checkOutput("bytes_used", 64'(idx), 64'(n));
`ifdef DSC_UNPACK_CRC_EN
                checkOutput("crc_valid", crcValid, 1'b1);
                checkOutput("crc_value", crcOut, crcModel());
                lastCrc = crcOut;
`endif
            end else begin
                checkOutput("busy_in_slice", busy, 1'b1);
            end
            @(posedge clk); #1;
        end
        inValid = 1'b0; start = 1'b0; outReady = 1'b1;
        if (!doneSeen) begin
            checkOutput("done_timeout", 0, 1);
        end
        @(negedge clk);
        checkOutput("done_pulse_width", done, 1'b0);
        checkOutput("busy_after_done", busy, 1'b0);
`ifdef DSC_UNPACK_CRC_EN
        checkOutput("crc_valid_pulse", crcValid, 1'b0);
        checkOutput("crc_hold", crcOut, crcModel());
`endif
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput(tag, {inReady, outValid, outData, outBen, outLastChunk, outLastSlice, busy, done, errCfg}, '0);
`ifdef DSC_UNPACK_CRC_EN
        checkOutput({tag, "_crc"}, {crcOut, crcValid}, '0);
`endif
    endtask

    initial begin
        rstN = 1'b1; start = 1'b0; cfgChunkSize = '0; cfgSliceHeight = '0;
        inValid = 1'b0; inData = '0; outReady = 1'b1;
        firstWordData = '0; lastCrc = '0;
        #3 rstN = 1'b0;
        #1 checkAllZero("reset_state");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        checkAllZero("after_reset_release");

        // Directed: single full word, then two rows of 8 bytes.
        fillCount(1, 6);
        applyStimulus(6, 1, 100, 100, -1, 0, 0);
        checkOutput("t1_word_const", firstWordData, 48'h010203040506);
        fillCount(0, 16);
        applyStimulus(8, 2, 100, 100, -1, 0, 0);
        fillCount(0, 16);
        applyStimulus(8, 2, 100, 100, 3, 5, 0);

        // Zero chunk size and zero height both flag err_cfg and stay idle.
        @(posedge clk); #1;
        start = 1'b1; cfgChunkSize = 16'd0; cfgSliceHeight = 16'd1;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_zero_chunk", errCfg, 1'b1);
        checkOutput("err_busy", busy, 1'b0);
        checkOutput("err_in_ready", inReady, 1'b0);
        fillCount(8'h40, 3);
        applyStimulus(3, 1, 100, 100, -1, 0, 0);
        @(posedge clk); #1;
        start = 1'b1; cfgChunkSize = 16'd5; cfgSliceHeight = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        checkOutput("err_zero_height", errCfg, 1'b1);
        checkOutput("err_height_busy", busy, 1'b0);

        // Reset mid-slice: everything clears at once and no done follows.
        fillRandom(12);
        applyStimulus(4, 3, 100, 100, -1, 0, 4);
        #2 rstN = 1'b0;
        #1 checkAllZero("mid_slice_reset");
        inValid = 1'b0; start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rstN = 1'b1;
        expQ.delete();
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checkOutput("no_done_after_reset", {done, busy, outValid}, '0);
        end
        fillRandom(12);
        applyStimulus(4, 3, 100, 100, -1, 0, 0);

`ifdef DSC_UNPACK_CRC_EN
        stim = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        applyStimulus(9, 1, 100, 100, -1, 0, 0);
        checkOutput("crc_check_value", lastCrc, 16'h29B1);
`endif

        // Random slices with random pacing on both sides.
        for (int t = 0; t < 25; t++) begin
            int c, h;
            c = $urandom_range(20, 1);
            h = $urandom_range(4, 1);
            fillRandom(c * h);
            applyStimulus(c, h, $urandom_range(100, 30), $urandom_range(100, 30), -1, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
